// File: rtl/mem_io_pkg.sv
// Shared encodings for the data-side bus arbiter: FSM states, requester codes, I/O map.
// No logic of its own; no latency.
// No backpressure; constants only.
package mem_io_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DBG = 1'b1
    } owner_t;

    // The I/O bank is selected by a single address bit (base 0x80); the word offset is addr[6:2].
    localparam int IO_SEL_BIT = 7;
    localparam int IO_WORD_W  = 5;

    localparam logic [IO_WORD_W-1:0] IO_WORD_P0 = 5'd0;  // 0x0: in_port0 / out_port0
    localparam logic [IO_WORD_W-1:0] IO_WORD_P1 = 5'd1;  // 0x4: in_port1 / out_port1
    localparam logic [IO_WORD_W-1:0] IO_WORD_P2 = 5'd2;  // 0x8: out_port2 (reads return 0)

    function automatic logic io_word_mapped(input logic [IO_WORD_W-1:0] w);
        return w <= IO_WORD_P2;
    endfunction

endpackage

// File: rtl/io_port_bank.sv
// Memory-mapped I/O: 2-flop input synchronisers, three output registers, offset decode, sticky bus_err.
// Reads are combinational from the synchronised inputs; writes land at the end of the io_en cycle.
// No backpressure: io_en is a single-cycle strobe that always completes.
module io_port_bank
    import mem_io_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [DW-1:0]        in_port0,
    input  logic [DW-1:0]        in_port1,
    input  logic                 io_en,
    input  logic                 io_we,
    input  logic [IO_WORD_W-1:0] io_word,
    input  logic [DW-1:0]        io_wdata,
    output logic [DW-1:0]        io_rdata,
    output logic [DW-1:0]        out_port0,
    output logic [DW-1:0]        out_port1,
    output logic [DW-1:0]        out_port2,
    output logic                 bus_err
);

    logic [DW-1:0] in0_s1_q, in0_s1_d, in0_s2_q, in0_s2_d;
    logic [DW-1:0] in1_s1_q, in1_s1_d, in1_s2_q, in1_s2_d;
    logic [DW-1:0] out0_q, out0_d, out1_q, out1_d, out2_q, out2_d;
    logic          bus_err_q, bus_err_d;

    // Next-state: synchroniser shift, decoded port writes, sticky error on unmapped offsets.
    always_comb begin
        in0_s1_d  = in_port0;
        in0_s2_d  = in0_s1_q;
        in1_s1_d  = in_port1;
        in1_s2_d  = in1_s1_q;
        out0_d    = out0_q;
        out1_d    = out1_q;
        out2_d    = out2_q;
        bus_err_d = bus_err_q;
        if (io_en) begin
            if (!io_word_mapped(io_word)) begin
                bus_err_d = 1'b1;
            end else if (io_we) begin
                case (io_word)
                    IO_WORD_P0: out0_d = io_wdata;
                    IO_WORD_P1: out1_d = io_wdata;
                    IO_WORD_P2: out2_d = io_wdata;
                    default:    ;
                endcase
            end
        end
    end

    // Read mux: only the two input ports are readable, everything else reads as zero.
    always_comb begin
        io_rdata = '0;
        case (io_word)
            IO_WORD_P0: io_rdata = in0_s2_q;
            IO_WORD_P1: io_rdata = in1_s2_q;
            default:    io_rdata = '0;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            in0_s1_q  <= '0;
            in0_s2_q  <= '0;
            in1_s1_q  <= '0;
            in1_s2_q  <= '0;
            out0_q    <= '0;
            out1_q    <= '0;
            out2_q    <= '0;
            bus_err_q <= 1'b0;
        end else begin
            in0_s1_q  <= in0_s1_d;
            in0_s2_q  <= in0_s2_d;
            in1_s1_q  <= in1_s1_d;
            in1_s2_q  <= in1_s2_d;
            out0_q    <= out0_d;
            out1_q    <= out1_d;
            out2_q    <= out2_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign out_port0 = out0_q;
    assign out_port1 = out1_q;
    assign out_port2 = out2_q;
    assign bus_err   = bus_err_q;

endmodule

// File: rtl/mem_io_arbiter.sv
// Two-requester (CPU, debug) data-bus arbiter with RAM / I/O decode and a starvation guard for debug.
// Request sampled in IDLE at cycle t -> one-cycle ack at t+2; next grant no earlier than t+3.
// Requesters hold req until ack; cpu_stall = cpu_req & ~cpu_ack holds the pipeline meanwhile.
module mem_io_arbiter
    import mem_io_pkg::*;
#(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int RAM_AW       = 5,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [AW-1:0]     cpu_addr,
    input  logic [DW-1:0]     cpu_wdata,
    output logic [DW-1:0]     cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [AW-1:0]     dbg_addr,
    input  logic [DW-1:0]     dbg_wdata,
    output logic [DW-1:0]     dbg_rdata,
    output logic              dbg_ack,
    output logic              ram_en,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [DW-1:0]     ram_wdata,
    input  logic [DW-1:0]     ram_rdata,
    input  logic [DW-1:0]     in_port0,
    input  logic [DW-1:0]     in_port1,
    output logic [DW-1:0]     out_port0,
    output logic [DW-1:0]     out_port1,
    output logic [DW-1:0]     out_port2,
    output logic              bus_err
);

    localparam int              SW         = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0]   STARVE_MAX = SW'(STARVE_LIMIT);

    state_t                state_q, state_d;
    owner_t                owner_q, owner_d;
    logic                  we_q, we_d;
    logic                  io_q, io_d;
    logic [IO_WORD_W-1:0]  io_word_q, io_word_d;
    logic [DW-1:0]         wdata_q, wdata_d;
    logic [SW-1:0]         starve_q, starve_d;
    logic                  ram_en_q, ram_en_d;
    logic                  ram_we_q, ram_we_d;
    logic [RAM_AW-1:0]     ram_addr_q, ram_addr_d;
    logic                  cpu_ack_q, cpu_ack_d;
    logic                  dbg_ack_q, dbg_ack_d;
    logic [DW-1:0]         rdata_q, rdata_d;

    logic                  dbg_wins;
    logic                  io_en;
    logic [DW-1:0]         io_rdata;
    logic [DW-1:0]         resp_dat;
    logic                  unused_addr_bits;

    // Only the decode bits of the addresses matter; the rest are deliberately ignored.
    assign unused_addr_bits = ^{cpu_addr, dbg_addr};

    // Debug wins if CPU is idle or debug has lost STARVE_LIMIT arbitrations in a row.
    assign dbg_wins = dbg_req & (~cpu_req | (starve_q == STARVE_MAX));

    // Next-state for the IDLE -> ACCESS -> RESP sequence, grant latching and the starvation counter.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        we_d       = we_q;
        io_d       = io_q;
        io_word_d  = io_word_q;
        wdata_d    = wdata_q;
        starve_d   = starve_q;
        ram_en_d   = 1'b0;
        ram_we_d   = 1'b0;
        ram_addr_d = ram_addr_q;
        cpu_ack_d  = 1'b0;
        dbg_ack_d  = 1'b0;
        rdata_d    = rdata_q;
        if (!dbg_req) begin
            starve_d = '0;
        end
        case (state_q)
            ST_IDLE: begin
                if (cpu_req || dbg_req) begin
                    state_d    = ST_ACCESS;
                    owner_d    = dbg_wins ? OWN_DBG : OWN_CPU;
                    we_d       = dbg_wins ? dbg_we : cpu_we;
                    io_d       = dbg_wins ? dbg_addr[IO_SEL_BIT] : cpu_addr[IO_SEL_BIT];
                    io_word_d  = dbg_wins ? dbg_addr[IO_SEL_BIT-1:2] : cpu_addr[IO_SEL_BIT-1:2];
                    wdata_d    = dbg_wins ? dbg_wdata : cpu_wdata;
                    ram_addr_d = dbg_wins ? dbg_addr[RAM_AW+1:2] : cpu_addr[RAM_AW+1:2];
                    ram_en_d   = ~io_d;
                    ram_we_d   = ~io_d & we_d;
                    if (dbg_wins) begin
                        starve_d = '0;
                    end else if (dbg_req) begin
                        starve_d = starve_q + SW'(1);
                    end
                end
            end
            ST_ACCESS: begin
                state_d   = ST_RESP;
                cpu_ack_d = (owner_q == OWN_CPU);
                dbg_ack_d = (owner_q == OWN_DBG);
                rdata_d   = (io_q && !we_q) ? io_rdata : '0;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM and all registered outputs; reset abandons any access in flight without an ack.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            owner_q    <= OWN_CPU;
            we_q       <= 1'b0;
            io_q       <= 1'b0;
            io_word_q  <= '0;
            wdata_q    <= '0;
            starve_q   <= '0;
            ram_en_q   <= 1'b0;
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            cpu_ack_q  <= 1'b0;
            dbg_ack_q  <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            io_q       <= io_d;
            io_word_q  <= io_word_d;
            wdata_q    <= wdata_d;
            starve_q   <= starve_d;
            ram_en_q   <= ram_en_d;
            ram_we_q   <= ram_we_d;
            ram_addr_q <= ram_addr_d;
            cpu_ack_q  <= cpu_ack_d;
            dbg_ack_q  <= dbg_ack_d;
            rdata_q    <= rdata_d;
        end
    end

    assign io_en = (state_q == ST_ACCESS) && io_q;

    io_port_bank #(.DW(DW)) u_io (
        .clock     (clock),
        .reset     (reset),
        .in_port0  (in_port0),
        .in_port1  (in_port1),
        .io_en     (io_en),
        .io_we     (we_q),
        .io_word   (io_word_q),
        .io_wdata  (wdata_q),
        .io_rdata  (io_rdata),
        .out_port0 (out_port0),
        .out_port1 (out_port1),
        .out_port2 (out_port2),
        .bus_err   (bus_err)
    );

    // RAM read data only arrives in the RESP cycle, so it bypasses the capture register.
    assign resp_dat  = (!io_q && !we_q) ? ram_rdata : rdata_q;

    assign cpu_ack   = cpu_ack_q;
    assign dbg_ack   = dbg_ack_q;
    assign cpu_rdata = cpu_ack_q ? resp_dat : '0;
    assign dbg_rdata = dbg_ack_q ? resp_dat : '0;
    assign cpu_stall = cpu_req & ~cpu_ack_q;

    assign ram_en    = ram_en_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = wdata_q;

endmodule

// File: tb/tb_mem_io_arbiter.sv
module tb_mem_io_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic [31:0] cpu_rdata;
    logic        cpu_ack, cpu_stall;
    logic        dbg_req = 1'b0, dbg_we = 1'b0;
    logic [31:0] dbg_addr = '0, dbg_wdata = '0;
    logic [31:0] dbg_rdata;
    logic        dbg_ack;
    logic        ram_en, ram_we;
    logic [4:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata = '0;
    logic [31:0] in_port0 = '0, in_port1 = '0;
    logic [31:0] out_port0, out_port1, out_port2;
    logic        bus_err;

    int checks = 0;
    int errors = 0;

    mem_io_arbiter dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata),
        .in_port0(in_port0), .in_port1(in_port1),
        .out_port0(out_port0), .out_port1(out_port1), .out_port2(out_port2),
        .bus_err(bus_err)
    );

    always #5 clock = ~clock;

    // Behavioural data RAM attached to the DUT: read data appears the cycle after ram_en.
    logic [31:0] bram [32];
    initial for (int i = 0; i < 32; i++) bram[i] = '0;
    always @(posedge clock) begin
        if (ram_en) begin
            if (ram_we) bram[ram_addr] <= ram_wdata;
            ram_rdata <= bram[ram_addr];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level reference: each granted access resolves immediately against a word
    // memory / port map; the ack is scheduled two edges later and the bus is free three edges later.
    logic [31:0] m_mem [32];
    logic [31:0] m_out [3];
    logic [31:0] m_in0_prev = '0, m_in1_prev = '0;
    logic [31:0] m_rdata = '0, m_wd = '0;
    logic        m_cpu_ack = 1'b0, m_dbg_ack = 1'b0, m_berr = 1'b0;
    logic        m_live = 1'b0, m_io = 1'b0, m_we = 1'b0, m_dbg_owner = 1'b0;
    int          m_word = 0;
    int          m_cnt = 0;
    int          m_starve = 0;
    initial for (int i = 0; i < 32; i++) m_mem[i] = '0;

    always @(posedge clock) begin
        if (reset) begin
            m_live = 1'b1;
            m_cnt = 0; m_cpu_ack = 1'b0; m_dbg_ack = 1'b0; m_rdata = '0;
            m_starve = 0; m_berr = 1'b0; m_in0_prev = '0; m_in1_prev = '0;
            for (int i = 0; i < 3; i++) m_out[i] = '0;
        end else begin
            if (m_cnt > 0) m_cnt--;
            if (m_cnt == 2) begin
                m_cpu_ack = !m_dbg_owner;
                m_dbg_ack = m_dbg_owner;
                if (m_io) begin
                    if (m_word > 2) m_berr = 1'b1;
                    else if (m_we) m_out[m_word] = m_wd;
                end
            end else if (m_cnt == 1) begin
                m_cpu_ack = 1'b0;
                m_dbg_ack = 1'b0;
            end
            if (!dbg_req) m_starve = 0;
            if (m_cnt == 0 && (cpu_req || dbg_req)) begin
                logic [31:0] a;
                m_dbg_owner = dbg_req && (!cpu_req || m_starve == 4);
                if (m_dbg_owner) m_starve = 0;
                else if (dbg_req) m_starve++;
                a      = m_dbg_owner ? dbg_addr : cpu_addr;
                m_we   = m_dbg_owner ? dbg_we : cpu_we;
                m_wd   = m_dbg_owner ? dbg_wdata : cpu_wdata;
                m_io   = a[7];
                m_word = int'(a[6:2]);
                if (m_we) m_rdata = '0;
                else if (m_io) m_rdata = (m_word == 0) ? m_in0_prev : (m_word == 1) ? m_in1_prev : '0;
                else m_rdata = m_mem[m_word];
                if (!m_io && m_we) m_mem[m_word] = m_wd;
                m_cnt = 3;
            end
            m_in0_prev = in_port0;
            m_in1_prev = in_port1;
        end
    end

    // Every-cycle comparison of DUT outputs against the reference.
    always @(negedge clock) begin
        if (m_live) begin
            chk("cpu_ack", {31'd0, cpu_ack}, {31'd0, m_cpu_ack});
            chk("dbg_ack", {31'd0, dbg_ack}, {31'd0, m_dbg_ack});
            chk("cpu_rdata", cpu_rdata, m_cpu_ack ? m_rdata : 32'd0);
            chk("dbg_rdata", dbg_rdata, m_dbg_ack ? m_rdata : 32'd0);
            chk("cpu_stall", {31'd0, cpu_stall}, {31'd0, cpu_req & ~m_cpu_ack});
            chk("ram_en", {31'd0, ram_en}, {31'd0, (m_cnt == 3) && !m_io});
            chk("ram_we", {31'd0, ram_we}, {31'd0, (m_cnt == 3) && !m_io && m_we});
            chk("out_port0", out_port0, m_out[0]);
            chk("out_port1", out_port1, m_out[1]);
            chk("out_port2", out_port2, m_out[2]);
            chk("bus_err", {31'd0, bus_err}, {31'd0, m_berr});
        end
    end

    // One access from either port; called aligned 1 time unit after a rising edge, returns likewise
    // with one idle cycle appended so that the next call starts a fresh arbitration.
    task automatic do_acc(input bit dbg, input bit we, input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output int lat, output int stall_cyc);
        bit got;
        got = 0; lat = 0; stall_cyc = 0; rd = '0;
        if (dbg) begin dbg_req = 1; dbg_we = we; dbg_addr = addr; dbg_wdata = wd; end
        else     begin cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd; end
        #1;
        if (cpu_stall) stall_cyc++;
        while (!got && lat < 20) begin
            @(posedge clock); #1;
            lat++;
            if (dbg ? dbg_ack : cpu_ack) begin
                got = 1;
                rd  = dbg ? dbg_rdata : cpu_rdata;
            end else if (cpu_stall) begin
                stall_cyc++;
            end
        end
        if (dbg) dbg_req = 0; else cpu_req = 0;
        if (!got) begin
            checks++; errors++;
            $display("FAIL ack_timeout: no ack within %0d cycles for addr %h", lat, addr);
        end
        @(posedge clock); #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int lat, sc;
        int seq[$];
        int exp_seq[6] = '{0, 0, 0, 0, 1, 0};

        repeat (3) @(posedge clock);
        #1;
        chk("rst_cpu_ack", {31'd0, cpu_ack}, 32'd0);
        chk("rst_out_port0", out_port0, 32'd0);
        chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
        chk("rst_ram_en", {31'd0, ram_en}, 32'd0);
        reset = 0;
        @(posedge clock); #1;

        // 1: RAM write then read back
        do_acc(0, 1, 32'h10, 32'h1234, rd, lat, sc);
        chk("t1_wr_lat", lat, 2);
        chk("t1_wr_stall", sc, 2);
        chk("t1_wr_rdata", rd, 32'h0);
        do_acc(0, 0, 32'h10, 32'h0, rd, lat, sc);
        chk("t1_rd_lat", lat, 2);
        chk("t1_rd_stall", sc, 2);
        chk("t1_rd_rdata", rd, 32'h1234);

        // 2: output port writes
        do_acc(0, 1, 32'h80, 32'h5, rd, lat, sc);
        do_acc(0, 1, 32'h88, 32'hA, rd, lat, sc);
        chk("t2_out_port0", out_port0, 32'h5);
        chk("t2_out_port2", out_port2, 32'hA);
        chk("t2_out_port1", out_port1, 32'h0);

        // 3: synchronised input reads
        in_port1 = 32'h18;
        in_port0 = 32'h77;
        repeat (3) @(posedge clock);
        #1;
        do_acc(0, 0, 32'h84, 32'h0, rd, lat, sc);
        chk("t3_in1", rd, 32'h18);
        do_acc(0, 0, 32'h80, 32'h0, rd, lat, sc);
        chk("t3_in0", rd, 32'h77);
        in_port1 = 32'h55;
        do_acc(0, 0, 32'h84, 32'h0, rd, lat, sc);
        chk("t3_in1_old", rd, 32'h18);
        do_acc(0, 0, 32'h84, 32'h0, rd, lat, sc);
        chk("t3_in1_new", rd, 32'h55);

        // 4: both ports requesting continuously
        dbg_we = 0; dbg_addr = 32'h14;
        cpu_we = 0; cpu_addr = 32'h10;
        cpu_req = 1; dbg_req = 1;
        for (int c = 0; c < 26; c++) begin
            @(posedge clock); #1;
            if (cpu_ack) seq.push_back(0);
            if (dbg_ack) seq.push_back(1);
        end
        cpu_req = 0; dbg_req = 0;
        repeat (4) @(posedge clock);
        #1;
        chk("t4_grants", {31'd0, seq.size() >= 6}, 32'd1);
        for (int i = 0; i < 6 && i < seq.size(); i++)
            chk($sformatf("t4_owner%0d", i), seq[i], exp_seq[i]);

        // 5: unmapped I/O offset from debug
        do_acc(1, 0, 32'h8C, 32'h0, rd, lat, sc);
        chk("t5_lat", lat, 2);
        chk("t5_rdata", rd, 32'h0);
        chk("t5_bus_err", {31'd0, bus_err}, 32'd1);
        do_acc(0, 1, 32'h14, 32'h99, rd, lat, sc);
        do_acc(0, 0, 32'h80, 32'h0, rd, lat, sc);
        chk("t5_bus_err_sticky", {31'd0, bus_err}, 32'd1);

        // 6: reset during ACCESS of an I/O write
        do_acc(0, 1, 32'h84, 32'h99, rd, lat, sc);
        chk("t6_pre_out1", out_port1, 32'h99);
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h84; cpu_wdata = 32'h33;
        @(posedge clock); #1;
        reset = 1; cpu_req = 0;
        @(posedge clock); #1;
        reset = 0;
        chk("t6_out1", out_port1, 32'h0);
        chk("t6_bus_err", {31'd0, bus_err}, 32'd0);
        for (int c = 0; c < 4; c++) begin
            @(posedge clock); #1;
            chk("t6_no_ack", {31'd0, cpu_ack}, 32'd0);
        end
        do_acc(0, 0, 32'h14, 32'h0, rd, lat, sc);
        chk("t6_post_lat", lat, 2);
        chk("t6_post_rdata", rd, 32'h99);

        repeat (3) @(posedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
